load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the MEM pipeline stage and `data_mem` and turns RV64I load/store requests (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD) into doubleword-aligned `data_mem` accesses. It performs byte-lane extraction, sign and zero extension on loads, and read-modify-write merging for sub-doubleword stores. It also detects misaligned or illegal accesses and returns one response per accepted request over a valid/ready handshake.

## Interface
Parameters:
- none; data path fixed at 64 bits, little-endian byte lanes.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  1 only in IDLE and not in reset; a request is accepted on an edge where `req_valid && req_ready`.
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV64 funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; 111 is illegal; ≥100 is illegal for stores.
- `req_addr`  in  64  byte address.
- `req_wdata`  in  64  store data, right-aligned; upper bytes are ignored per size.
- `resp_valid`  out  1  one-cycle pulse per accepted request.
- `resp_rdata`  out  64  load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned access or illegal funct3; valid with `resp_valid`.
- `mem_read`  out  1  to `data_mem` MemRead.
- `mem_write`  out  1  to `data_mem` MemWrite.
- `mem_addr`  out  64  `{req_addr[63:3],3'b000}`, held for the whole operation.
- `mem_wdata`  out  64  to `data_mem` write_data.
- `mem_rdata`  in  64  from `data_mem` read_data; combinational, gated by MemRead.

## Operation
- All request fields are captured into internal registers on accept. Inputs are ignored outside IDLE.
- `o = addr[2:0]`. Misalignment rules:
  - H with `addr[0]=1`
  - W/WU with `addr[1:0]≠0`
  - D with `o≠0`
  - B is never misaligned.
- States:
  - IDLE: `req_ready=1`. On accept:
    - error → ERR
    - load → RD
    - store D → WR
    - store B/H/W → RD
  - RD: `mem_read=1`. At the edge, `mem_rdata` is captured into `rbuf`. Then a load goes to RESP; a store goes to WR.
  - WR: `mem_write=1`.
    - `mem_wdata` = `req_wdata` for SD.
    - Otherwise it is `rbuf` with byte lanes `o..o+n-1` replaced by `req_wdata[8n-1:0]` (n = 1/2/4).
    - Next state RESP.
  - RESP: `resp_valid=1`, `resp_err=0`. Next state IDLE.
  - ERR: `resp_valid=1`, `resp_err=1`, `resp_rdata=0`. No mem strobe at any point. Next state IDLE.
- Load result is formed from `s = rbuf >> (8*o)`:
  - B: sext(`s[7:0]`)
  - H: sext(`s[15:0]`)
  - W: sext(`s[31:0]`)
  - D: `s`
  - BU/HU/WU: zero-extended
- `mem_read` and `mem_write` are never high in the same cycle.
- `mem_wdata` is 0 when `mem_write=0`.

## Timing
- Accept edge = edge 0.
- Latency to the `resp_valid` cycle:
  - LD/loads: 2 (RD, RESP)
  - SD: 2 (WR, RESP)
  - SB/SH/SW: 3 (RD, WR, RESP)
  - error: 1 (ERR)
- `req_ready` returns high in the cycle after RESP/ERR. Max throughput is one load per 3 cycles.
- Reset state is IDLE. While `rst=1` and in the cycle after, outputs are:
  - `req_ready` = 0 while `rst=1`, 1 after
  - `resp_valid` = 0, `resp_err` = 0
  - `resp_rdata` = 0
  - `mem_read` = 0, `mem_write` = 0
  - `mem_addr` = 0, `mem_wdata` = 0
- Reset mid-operation:
  - Mem strobes are decoded from the state register. A WR cycle in which `rst` is sampled still commits its write at that edge; this is the only side effect.
  - No response is issued for the aborted request.
- `req_valid` held high across a busy period is accepted only at the next IDLE edge; it is never dropped or double-accepted.

## Test plan
- SD `0x12345678ABCDEF00` @0x08:
  - `mem_write=1` with `mem_addr=0x08` in cycle 1.
  - `resp_valid`, `resp_err=0` in cycle 2.
  - Follow-up LD @0x08 returns `0x12345678ABCDEF00` in its cycle 2.
- Loads on that dword:
  - LB @0x0B → `0xFFFFFFFFFFFFFFAB`
  - LBU @0x0B → `0x00000000000000AB`
  - LH @0x0A → `0xFFFFFFFFFFFFABCD`
  - LW @0x0C → `0x0000000012345678`
  - LWU @0x0C → `0x0000000012345678`
- Sub-doubleword stores:
  - SB `req_wdata=0xFFFF_FFFF_FFFF_FF5A` @0x09: RD, WR, RESP; memory becomes `0x12345678ABCD5A00`.
  - Then SH `0xBEEF` @0x0E: memory becomes `0xBEEF5678ABCD5A00`.
- Errors:
  - LW @0x0A → `resp_valid`, `resp_err=1`, `resp_rdata=0` in cycle 1; `mem_read` and `mem_write` never asserted.
  - Store with funct3=100 gives the same result.
- Reset mid-operation: `rst` pulsed during the RD cycle of SB @0x08 → no `mem_write`, no `resp_valid`, `req_ready=1` after reset, LD @0x08 returns the unchanged value.
- `req_valid` held for three back-to-back LDs (@0x08, @0x10, @0x08) → exactly three `resp_valid` pulses, on cycles 2, 5 and 8, with correct data.

Source files
------------

// File: rtl/load_store_unit.sv
// RV64I load/store unit: converts byte-addressed LB..LD / SB..SD requests into
// doubleword-aligned data_mem reads and writes, with lane extraction and RMW merge.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        is_store_r;
    logic [2:0]  funct3_r;
    logic [63:0] addr_r;
    logic [63:0] wdata_r;
    logic [63:0] rbuf_r;
    logic        accept_s;
    logic        err_s;
    logic        store_d_s;

    // Size is funct3[1:0]; 111 and any unsigned-size store have no meaning.
    function automatic logic access_error(input logic st, input logic [2:0] f3,
                                          input logic [2:0] o);
        logic misaligned;
        case (f3[1:0])
            2'b01:   misaligned = o[0];
            2'b10:   misaligned = (o[1:0] != 2'b00);
            2'b11:   misaligned = (o != 3'b000);
            default: misaligned = 1'b0;
        endcase
        return misaligned | (f3 == 3'b111) | (st & f3[2]);
    endfunction

    function automatic logic [63:0] load_extract(input logic [63:0] buf_d,
                                                 input logic [2:0] f3,
                                                 input logic [2:0] o);
        logic [63:0] s;
        s = buf_d >> {o, 3'b000};
        case (f3)
            3'b000:  return {{56{s[7]}}, s[7:0]};
            3'b001:  return {{48{s[15]}}, s[15:0]};
            3'b010:  return {{32{s[31]}}, s[31:0]};
            3'b011:  return s;
            3'b100:  return {56'd0, s[7:0]};
            3'b101:  return {48'd0, s[15:0]};
            3'b110:  return {32'd0, s[31:0]};
            default: return 64'd0;
        endcase
    endfunction

    // Replace lanes o..o+n-1 of the old dword with the low n bytes of the store data.
    function automatic logic [63:0] store_merge(input logic [63:0] buf_d,
                                                input logic [63:0] wd,
                                                input logic [1:0] sz,
                                                input logic [2:0] o);
        logic [63:0] mask;
        case (sz)
            2'b00:   mask = 64'h0000_0000_0000_00FF;
            2'b01:   mask = 64'h0000_0000_0000_FFFF;
            2'b10:   mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return (buf_d & ~(mask << {o, 3'b000})) | ((wd & mask) << {o, 3'b000});
    endfunction

    // Next-state decode.
    always_comb begin
        state_s   = state_r;
        accept_s  = req_valid && (state_r == IDLE);
        err_s     = access_error(req_is_store, req_funct3, req_addr[2:0]);
        store_d_s = (funct3_r[1:0] == 2'b11);
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (err_s) begin
                        state_s = ERR;
                    end else if (req_is_store && (req_funct3[1:0] == 2'b11)) begin
                        state_s = WR;
                    end else begin
                        state_s = RD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD:      state_s = is_store_r ? WR : RESP;
            WR:      state_s = RESP;
            RESP:    state_s = IDLE;
            ERR:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register, request capture and read buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            is_store_r <= 1'b0;
            funct3_r   <= 3'd0;
            addr_r     <= 64'd0;
            wdata_r    <= 64'd0;
            rbuf_r     <= 64'd0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                is_store_r <= req_is_store;
                funct3_r   <= req_funct3;
                addr_r     <= req_addr;
                wdata_r    <= req_wdata;
            end else begin
                is_store_r <= is_store_r;
                funct3_r   <= funct3_r;
                addr_r     <= addr_r;
                wdata_r    <= wdata_r;
            end
            rbuf_r <= (state_r == RD) ? mem_rdata : rbuf_r;
        end
    end

    // Outputs decoded from registered state; a WR cycle still strobes under reset.
    always_comb begin
        req_ready  = (state_r == IDLE) && !rst;
        mem_read   = (state_r == RD);
        mem_write  = (state_r == WR);
        mem_addr   = {addr_r[63:3], 3'b000};
        mem_wdata  = 64'd0;
        if (state_r == WR) begin
            mem_wdata = store_d_s ? wdata_r
                                  : store_merge(rbuf_r, wdata_r, funct3_r[1:0], addr_r[2:0]);
        end else begin
            mem_wdata = 64'd0;
        end
        resp_valid = ((state_r == RESP) || (state_r == ERR)) && !rst;
        resp_err   = (state_r == ERR) && !rst;
        resp_rdata = ((state_r == RESP) && !is_store_r && !rst)
                   ? load_extract(rbuf_r, funct3_r, addr_r[2:0]) : 64'd0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table vectors, hand-written corner
// sequences and random requests against a byte-addressed memory reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // data_mem stand-in: 8 dwords covering byte addresses 0..63.
    logic [63:0] dmem [0:7];
    logic        clear_mem;
    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 8; i++) dmem[i] <= 64'd0;
        end else if (mem_write) begin
            dmem[mem_addr[5:3]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_read ? dmem[mem_addr[5:3]] : 64'd0;

    logic [63:0] ref_mem [0:7];
    int n_vec;
    int n_bad;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_err(input logic st, input logic [2:0] f3, input logic [63:0] a);
        return (int'(a[2:0]) % size_of(f3) != 0) || (f3 == 3'd7) || (st && f3 >= 3'd4);
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a);
        logic [63:0] v;
        int n;
        n = size_of(f3);
        v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a[5:3]][8*(int'(a[2:0]) + i) +: 8];
        if (f3 < 3'd4 && n < 8 && v[8*n-1]) begin
            for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
        end
        return v;
    endfunction

    function automatic int ref_lat(input logic st, input logic [2:0] f3, input logic [63:0] a);
        if (ref_err(st, f3, a)) return 1;
        if (!st || size_of(f3) == 8) return 2;
        return 3;
    endfunction

    task automatic wait_ready();
        int w;
        w = 0;
        while (!req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) chk("ready timeout", {63'd0, req_ready}, 64'd1);
    endtask

    // One request: drive, follow until response, compare timing, data and strobes.
    task automatic do_op(input logic st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] exp_rd,
                         input logic exp_er, input int exp_lat, input string tag);
        int n, lat, rdc, wrc, nrd, nwr, rd_exp, wr_exp;
        logic proto, er;
        logic [63:0] rd, nd, wd_seen;
        n = size_of(f3);
        rd_exp = (!exp_er && (!st || n < 8)) ? 1 : 0;
        wr_exp = (!exp_er && st) ? ((n == 8) ? 1 : 2) : 0;
        nd = ref_mem[a[5:3]];
        if (st && !exp_er) begin
            for (int i = 0; i < n; i++) nd[8*(int'(a[2:0]) + i) +: 8] = wd[8*i +: 8];
        end
        wait_ready();
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99; rdc = 0; wrc = 0; nrd = 0; nwr = 0; proto = 1'b1;
        rd = 64'hDEAD; er = 1'bx; wd_seen = 64'd0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_read && mem_write) proto = 1'b0;
            if (!mem_write && mem_wdata != 64'd0) proto = 1'b0;
            if ((mem_read || mem_write) && mem_addr != {a[63:3], 3'b000}) proto = 1'b0;
            if (mem_read) begin nrd++; if (rdc == 0) rdc = c; end
            if (mem_write) begin nwr++; if (wrc == 0) wrc = c; wd_seen = mem_wdata; end
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
            if (req_ready) proto = 1'b0;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " err"}, {63'd0, er}, {63'd0, exp_er});
        chk({tag, " rdata"}, rd, exp_rd);
        chk({tag, " read cycle"}, 64'(rdc), 64'(rd_exp));
        chk({tag, " write cycle"}, 64'(wrc), 64'(wr_exp));
        chk({tag, " strobe count"}, 64'(nrd + nwr), 64'((rd_exp != 0 ? 1 : 0) + (wr_exp != 0 ? 1 : 0)));
        chk({tag, " protocol"}, {63'd0, proto}, 64'd1);
        if (wr_exp != 0) chk({tag, " wdata"}, wd_seen, nd);
        if (st && !exp_er) ref_mem[a[5:3]] = nd;
    endtask

    task automatic rand_op(input int k);
        logic st;
        logic [2:0] f3;
        logic [63:0] a, wd, er_rd;
        logic er;
        st = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        a  = 64'($urandom_range(0, 63));
        wd = {$urandom, $urandom};
        er = ref_err(st, f3, a);
        er_rd = (st || er) ? 64'd0 : ref_load(f3, a);
        do_op(st, f3, a, wd, er_rd, er, ref_lat(st, f3, a), $sformatf("rand%0d", k));
    endtask

    initial begin
        int pulses, nw, nr;
        int pc [3];
        logic [63:0] pd [3];
        logic [63:0] e0, e1;
        logic rdy_after;

        n_vec = 0; n_bad = 0;
        tbl[0]  = '{1'b1, 3'd3, 64'h08, 64'h1234_5678_ABCD_EF00, 64'd0, 1'b0, 2};
        tbl[1]  = '{1'b0, 3'd3, 64'h08, 64'd0, 64'h1234_5678_ABCD_EF00, 1'b0, 2};
        tbl[2]  = '{1'b0, 3'd0, 64'h0B, 64'd0, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0, 2};
        tbl[3]  = '{1'b0, 3'd4, 64'h0B, 64'd0, 64'h0000_0000_0000_00AB, 1'b0, 2};
        tbl[4]  = '{1'b0, 3'd1, 64'h0A, 64'd0, 64'hFFFF_FFFF_FFFF_ABCD, 1'b0, 2};
        tbl[5]  = '{1'b0, 3'd2, 64'h0C, 64'd0, 64'h0000_0000_1234_5678, 1'b0, 2};
        tbl[6]  = '{1'b0, 3'd6, 64'h0C, 64'd0, 64'h0000_0000_1234_5678, 1'b0, 2};
        tbl[7]  = '{1'b1, 3'd0, 64'h09, 64'hFFFF_FFFF_FFFF_FF5A, 64'd0, 1'b0, 3};
        tbl[8]  = '{1'b0, 3'd3, 64'h08, 64'd0, 64'h1234_5678_ABCD_5A00, 1'b0, 2};
        tbl[9]  = '{1'b1, 3'd1, 64'h0E, 64'h0000_0000_0000_BEEF, 64'd0, 1'b0, 3};
        tbl[10] = '{1'b0, 3'd3, 64'h08, 64'd0, 64'hBEEF_5678_ABCD_5A00, 1'b0, 2};
        tbl[11] = '{1'b0, 3'd2, 64'h0A, 64'd0, 64'd0, 1'b1, 1};
        tbl[12] = '{1'b1, 3'd4, 64'h08, 64'h55, 64'd0, 1'b1, 1};
        tbl[13] = '{1'b0, 3'd3, 64'h0C, 64'd0, 64'd0, 1'b1, 1};
        tbl[14] = '{1'b0, 3'd7, 64'h08, 64'd0, 64'd0, 1'b1, 1};

        rst = 1'b1; clear_mem = 1'b1; req_valid = 1'b0; req_is_store = 1'b0;
        req_funct3 = 3'd0; req_addr = 64'd0; req_wdata = 64'd0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 64'd0;
        repeat (2) @(negedge clk);
        chk("rst req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst resp_valid", {62'd0, resp_valid, resp_err}, 64'd0);
        chk("rst strobes", {62'd0, mem_read, mem_write}, 64'd0);
        chk("rst mem_addr", mem_addr, 64'd0);
        chk("rst mem_wdata|rdata", mem_wdata | resp_rdata, 64'd0);
        rst = 1'b0; clear_mem = 1'b0;
        @(negedge clk);
        chk("post-rst req_ready", {63'd0, req_ready}, 64'd1);
        chk("post-rst outputs", {60'd0, resp_valid, resp_err, mem_read, mem_write}, 64'd0);
        chk("post-rst mem_addr", mem_addr, 64'd0);

        for (int i = 0; i < 15; i++) begin
            do_op(tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
                  tbl[i].err, tbl[i].lat, $sformatf("vec%0d", i));
        end

        // Reset during the RD cycle of SB @0x08 must leave memory untouched.
        wait_ready();
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd0;
        req_addr = 64'h08; req_wdata = 64'h77;
        @(posedge clk);
        #1 req_valid = 1'b0; rst = 1'b1;
        nw = 0; nr = 0;
        @(negedge clk);
        if (mem_write) nw++;
        if (resp_valid) nr++;
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_after = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) rdy_after = req_ready;
            if (mem_write) nw++;
            if (resp_valid) nr++;
        end
        chk("midrst writes", 64'(nw), 64'd0);
        chk("midrst responses", 64'(nr), 64'd0);
        chk("midrst ready", {63'd0, rdy_after}, 64'd1);
        do_op(1'b0, 3'd3, 64'h08, 64'd0, 64'hBEEF_5678_ABCD_5A00, 1'b0, 2, "midrst LD");

        for (int k = 0; k < 60; k++) rand_op(k);

        // Three LDs with req_valid held high: pulses in cycles 2, 5, 8.
        wait_ready();
        e0 = ref_mem[1]; e1 = ref_mem[2];
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd3; req_addr = 64'h08;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) req_addr = 64'h10;
            if (c == 3) req_addr = 64'h08;
            if (c == 6) req_valid = 1'b0;
            @(negedge clk);
            if (resp_valid) begin
                if (pulses < 3) begin
                    pc[pulses] = c + 1;
                    pd[pulses] = resp_rdata;
                end
                pulses++;
            end
        end
        chk("b2b pulses", 64'(pulses), 64'd3);
        if (pulses >= 3) begin
            chk("b2b cycle0", 64'(pc[0]), 64'd2);
            chk("b2b cycle1", 64'(pc[1]), 64'd5);
            chk("b2b cycle2", 64'(pc[2]), 64'd8);
            chk("b2b data0", pd[0], e0);
            chk("b2b data1", pd[1], e1);
            chk("b2b data2", pd[2], e0);
        end

        for (int i = 0; i < 8; i++) chk($sformatf("final dword%0d", i), dmem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
